sync_fifo_wr_arbiter: RTL and testbench



---
 rtl/sync_fifo_wr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sync_fifo_wr_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write arbiter sharing a single sync_fifo write port among N_REQ producers,
// with optional short burst locking so multi-beat records land contiguously.
module sync_fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          reqLast,
    input  logic [N_REQ*DATA_W-1:0]   reqData,
    input  logic                      fifoFull,
    output logic [N_REQ-1:0]          gnt,
    output logic                      fifoWrite,
    output logic [DATA_W-1:0]         fifoWData,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  owner
);

    localparam int PTR_W       = $clog2(N_REQ);
    localparam int CNT_W       = $clog2(MAX_BURST) + 1;
    localparam bit SINGLE_BEAT = (MAX_BURST == 32'sd1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [PTR_W-1:0]   ptr_r, ptr_nxt_s;
    logic [PTR_W-1:0]   owner_r, owner_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic [N_REQ-1:0]   gnt_s;
    logic [DATA_W-1:0]  data_s;
    logic [PTR_W:0]     pick_s;
    logic               found_s;
    logic [PTR_W-1:0]   win_s;

    // First requester at or after p, wrapping; MSB flags that anyone was found.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [PTR_W-1:0] p);
        logic [PTR_W:0] res;
        int             idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (r[PTR_W'(idx)]) begin
                res = {1'b1, PTR_W'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] nxt;
        if (p == PTR_W'(N_REQ - 1)) begin
            nxt = '0;
        end else begin
            nxt = p + PTR_W'(1);
        end
        return nxt;
    endfunction

    assign pick_s    = rr_pick(req, ptr_r);
    assign found_s   = pick_s[PTR_W];
    assign win_s     = pick_s[PTR_W-1:0];
    assign cnt_inc_s = cnt_r + CNT_W'(1);

    // Arbitration: grant selection and next-state for the lock FSM.
    always_comb begin
        gnt_s       = '0;
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        owner_nxt_s = owner_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s && !fifoFull) begin
                    gnt_s[win_s] = 1'b1;
                    if (reqLast[win_s] || SINGLE_BEAT) begin
                        ptr_nxt_s = ptr_inc(win_s);
                    end else begin
                        state_nxt_s = ST_BURST;
                        owner_nxt_s = win_s;
                        cnt_nxt_s   = CNT_W'(1);
                    end
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            ST_BURST: begin
                if (!req[owner_r]) begin
                    // Owner walked away: release without granting anyone this cycle.
                    state_nxt_s = ST_IDLE;
                    ptr_nxt_s   = ptr_inc(owner_r);
                    cnt_nxt_s   = '0;
                end else if (fifoFull) begin
                    cnt_nxt_s = cnt_r;
                end else begin
                    gnt_s[owner_r] = 1'b1;
                    if (reqLast[owner_r] || (cnt_inc_s == CNT_W'(MAX_BURST))) begin
                        state_nxt_s = ST_IDLE;
                        ptr_nxt_s   = ptr_inc(owner_r);
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Data mux for the granted requester; zero when nobody is granted.
    always_comb begin
        data_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_s[i]) begin
                data_s = reqData[i*DATA_W +: DATA_W];
            end else begin
                data_s = data_s;
            end
        end
    end

    // Write-port outputs are forced quiet while reset is asserted.
    always_comb begin
        if (rst) begin
            gnt       = gnt_s;
            fifoWData = data_s;
        end else begin
            gnt       = '0;
            fifoWData = '0;
        end
    end

    assign fifoWrite = |gnt;
    assign busy      = (state_r == ST_BURST);
    assign owner     = owner_r;

    // FSM, priority pointer, lock owner and beat counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            owner_r <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            owner_r <= owner_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Scoreboard bench for sync_fifo_wr_arbiter: directed per-cycle vectors push expected
// responses; a negedge monitor pops and compares them against the DUT outputs.
module tb_sync_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         reqLast;
    logic [N_REQ*DATA_W-1:0]  reqData;
    logic                     fifoFull;
    logic [N_REQ-1:0]         gnt;
    logic                     fifoWrite;
    logic [DATA_W-1:0]        fifoWData;
    logic                     busy;
    logic [1:0]               owner;

    typedef struct {
        logic [N_REQ-1:0]  gnt;
        logic [DATA_W-1:0] data;
        logic              busy;
        logic [1:0]        owner;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] data_tab [N_REQ];
    int unsigned       stamp = 0;
    int                n_checks = 0;
    int                n_pass = 0;

    sync_fifo_wr_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .reqLast(reqLast), .reqData(reqData),
        .fifoFull(fifoFull), .gnt(gnt), .fifoWrite(fifoWrite), .fifoWData(fifoWData),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the hand-computed response expected in that cycle.
    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lst,
                         input logic full, input logic [3:0] eg, input logic eb,
                         input logic [1:0] eo);
        exp_t e;
        @(posedge clk);
        #1;
        stamp = stamp + 1;
        for (int i = 0; i < N_REQ; i++) begin
            data_tab[i] = {4'(i), 4'hA, 24'(stamp)};
            reqData[i*DATA_W +: DATA_W] = data_tab[i];
        end
        rst      = r;
        req      = rq;
        reqLast  = lst;
        fifoFull = full;
        e.gnt   = eg;
        e.data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (eg[i]) e.data = data_tab[i];
        end
        e.busy  = eb;
        e.owner = eo;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks = n_checks + 1;
            if (gnt === e.gnt && fifoWrite === (|e.gnt) && fifoWData === e.data &&
                busy === e.busy && owner === e.owner) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL cycle_%0d: got gnt=%b wr=%b data=%h busy=%b owner=%0d, want gnt=%b wr=%b data=%h busy=%b owner=%0d",
                         n_checks, gnt, fifoWrite, fifoWData, busy, owner,
                         e.gnt, |e.gnt, e.data, e.busy, e.owner);
            end
        end
    end

    initial begin
        rst = 1'b0; req = '0; reqLast = '0; reqData = '0; fifoFull = 1'b0;
        // reset: outputs quiet even with requests present
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
        drive(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0);
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
        // plain round robin, single beats
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 4'b1111, 4'b1111, 1'b0, 4'(1 << (k % 4)), 1'b0, 2'd0);
        end
        // move ptr to 2, then requester 2 bursts 4 beats while 0 and 1 request
        drive(1'b1, 4'b0010, 4'b1111, 1'b0, 4'b0010, 1'b0, 2'd0);
        drive(1'b1, 4'b0111, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0);
        drive(1'b1, 4'b0111, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2);
        drive(1'b1, 4'b0111, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2);
        drive(1'b1, 4'b0111, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2);
        drive(1'b1, 4'b1011, 4'b1111, 1'b0, 4'b1000, 1'b0, 2'd2);
        drive(1'b1, 4'b0011, 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd2);
        // requester 1 streams without last: cut off at MAX_BURST, 3 next
        drive(1'b1, 4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd2);
        drive(1'b1, 4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1);
        drive(1'b1, 4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1);
        drive(1'b1, 4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1);
        drive(1'b1, 4'b1010, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd1);
        drive(1'b1, 4'b1010, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3);
        // FIFO full for 3 cycles at cnt=2, burst then completes
        drive(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd3);
        drive(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0);
        drive(1'b1, 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0);
        drive(1'b1, 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0);
        drive(1'b1, 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0);
        drive(1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0);
        drive(1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0);
        drive(1'b1, 4'b0011, 4'b1111, 1'b0, 4'b0010, 1'b0, 2'd0);
        // full while idle: no grant, ptr stays at 2
        drive(1'b1, 4'b0011, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0);
        drive(1'b1, 4'b0011, 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0);
        // owner drops req after one beat
        drive(1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0);
        drive(1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1);
        drive(1'b1, 4'b0101, 4'b1111, 1'b0, 4'b0100, 1'b0, 2'd1);
        // reset pulse mid-burst
        drive(1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd1);
        drive(1'b1, 4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3);
        drive(1'b0, 4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
        drive(1'b1, 4'b1001, 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0);
        drive(1'b1, 4'b1001, 4'b1111, 1'b0, 4'b1000, 1'b0, 2'd0);
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
        // drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) begin
            @(posedge clk);
        end
        if (sb_q.size() > 0) begin
            n_checks = n_checks + 1;
            $display("FAIL drain: %0d expected responses left, want 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
